context_switch_ctrl: RTL and testbench
======================================

CONTEXT_SWITCH_CTRL -- requirements
Module: context_switch_ctrl

Interface
REQ-001 SHALL have parameter VEC_TIMER, default 10'd4: handler address for timer preemption.
REQ-002 SHALL have parameter VEC_HALT, default 10'd8: handler address for process halt.
REQ-003 SHALL have parameter DEPTH, default 4: saved-PC stack depth; used only with CTX_NEST_EN.
REQ-004 SHALL have port clk  in  1  processor clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port int_clk  in  1  timer preemption request from the interruption block.
REQ-007 SHALL have port int_halt  in  1  process-halt request from the interruption block.
REQ-008 SHALL have port save_pc  in  10  PC captured by the interruption block at the event.
REQ-009 SHALL have port rfe  in  1  return-from-exception instruction decoded, one-cycle pulse.
REQ-010 SHALL have port ie_we  in  1  write strobe for the interrupt-enable bit.
REQ-011 SHALL have port ie_data  in  1  new interrupt-enable value.
REQ-012 SHALL have port pipe_stall  out  1  freeze fetch/decode.
REQ-013 SHALL have port pc_redirect  out  1  one-cycle pulse; PC mux selects redirect_pc.
REQ-014 SHALL have port redirect_pc  out  10  target PC while pc_redirect=1.
REQ-015 SHALL have port cause  out  2  00 none, 01 timer, 10 halt.
REQ-016 SHALL have port in_handler  out  1  high while handler code runs.
REQ-017 SHALL have port epc  out  10  top of saved-PC storage.
REQ-018 SHALL have port overflow  out  1  sticky nesting-overflow flag.

Function
REQ-019 SHALL use FSM states IDLE, SAVE, REDIRECT, HANDLER, RETURN; Moore outputs decoded from state.
REQ-020 SHALL leave IDLE for SAVE when int_halt=1, or when int_clk=1 with ie=1, or when a pending flag is set; otherwise remain in IDLE.
REQ-021 SHALL give halt priority over timer when both are present in one cycle; the timer request becomes pending.
REQ-022 SHALL, in SAVE (1 cycle): assert pipe_stall, push save_pc into epc storage, and latch cause.
REQ-023 SHALL, in REDIRECT (1 cycle): assert pipe_stall and pc_redirect, drive redirect_pc=VEC_HALT or VEC_TIMER per cause.
REQ-024 SHALL hold HANDLER with in_handler=1 until rfe=1, then go to RETURN.
REQ-025 SHALL, in RETURN (1 cycle): assert pc_redirect with redirect_pc=epc, pop epc, set cause=00, then go to IDLE.
REQ-026 SHALL give a latency of 2 cycles from the sampled event to pc_redirect, and 1 cycle from rfe to pc_redirect.
REQ-027 SHALL ignore int_clk when ie=0, with no pending flag set; int_halt is non-maskable.
REQ-028 SHALL update ie on ie_we in any state; ie SHALL NOT be altered by the FSM.
REQ-029 SHALL ignore rfe in any state other than HANDLER.
REQ-030 SHALL drive redirect_pc=0 whenever pc_redirect=0.

Reset
REQ-031 SHALL on rst force IDLE, pipe_stall=0, pc_redirect=0, redirect_pc=0, cause=00, in_handler=0, epc=0, overflow=0, ie=1, pending flags clear, stack empty.
REQ-032 SHALL give rst priority over every other input, including mid-handler and mid-SAVE; the saved context is discarded.

Configuration
REQ-033 SHALL use macro CTX_NEST_EN to select nesting.
REQ-034 SHALL, without CTX_NEST_EN: use a single epc register; events arriving in SAVE/REDIRECT/HANDLER/RETURN set the halt or timer pending flag (timer only if ie=1), which is serviced from IDLE; overflow is tied 0.
REQ-035 SHALL, with CTX_NEST_EN: use a DEPTH-entry LIFO; an event in HANDLER re-enters SAVE and pushes save_pc; on return, cause is restored from the stacked entry.
REQ-036 SHALL, with CTX_NEST_EN, on a push to a full stack: set overflow, drop the event, and stay in HANDLER with the stack unchanged.

Structure
REQ-037 SHALL keep the state enum, cause codes and default vectors in shared package ctx_pkg.
REQ-038 SHALL implement saved-PC storage as sub-module epc_stack (depth 1 without CTX_NEST_EN).

Verification
REQ-039 SHALL test: ie=1, int_clk=1 with save_pc=0x123 -> pipe_stall for 2 cycles, pc_redirect with redirect_pc=0x004, cause=01, epc=0x123.
REQ-040 SHALL test: int_clk and int_halt in the same cycle -> redirect to 0x008, cause=10; after rfe, return to epc, then timer entry at 0x004.
REQ-041 SHALL test: ie=0, int_clk pulse -> no state change; int_halt -> redirect to 0x008.
REQ-042 SHALL test: rfe 1 cycle after entering HANDLER with epc=0x0AA -> pc_redirect with 0x0AA next cycle, then cause=00 and in_handler=0.
REQ-043 SHALL test: rst asserted in HANDLER -> all outputs at reset values the next cycle.
REQ-044 SHALL test, with CTX_NEST_EN: 5 nested timer events -> epc stack holds 4 entries, overflow=1; 4 rfes unwind epcs in LIFO order.

Source files
------------

// File: rtl/ctx_pkg.sv
// ctx_pkg: shared FSM states, cause codes, default handler vectors and stack entry type.
package ctx_pkg;
  typedef enum logic [2:0] {IDLE, SAVE, REDIRECT, HANDLER, RETURN} state_t;
  typedef enum logic [1:0] {CAUSE_NONE = 2'b00, CAUSE_TIMER = 2'b01, CAUSE_HALT = 2'b10} cause_t;
  localparam logic [9:0] VEC_TIMER_DEF = 10'd4;
  localparam logic [9:0] VEC_HALT_DEF = 10'd8;
  typedef struct packed {
    cause_t     cause;
    logic [9:0] pc;
  } ctx_t;
endpackage

// File: rtl/epc_stack.sv
// epc_stack: LIFO of saved contexts; exposes top PC and the cause of the entry beneath it.
module epc_stack
  import ctx_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  ctx_t       din,
  output logic [9:0] top_pc,
  output cause_t     next_cause,
  output logic       full,
  output logic       multi
);
  localparam int CW = $clog2(DEPTH + 1);
  ctx_t mem_q [DEPTH];
  ctx_t mem_d [DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;
  assign full = int'(cnt_q) == DEPTH;
  assign multi = int'(cnt_q) > 1;
  always_comb begin
    mem_d = mem_q;
    top_pc = '0;
    next_cause = CAUSE_NONE;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == int'(cnt_q) - 1) top_pc = mem_q[i].pc;
      if (i == int'(cnt_q) - 2) next_cause = mem_q[i].cause;
      if (push && !full && i == int'(cnt_q)) mem_d[i] = din;
    end
    cnt_d = (push && !full) ? cnt_q + CW'(1) : (pop && cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end
endmodule

// File: rtl/context_switch_ctrl.sv
// context_switch_ctrl: trap entry/return sequencer for timer and halt events.
// Define CTX_NEST_EN for nested handlers on a DEPTH-entry saved-context stack.
module context_switch_ctrl
  import ctx_pkg::*;
#(
  parameter logic [9:0] VEC_TIMER = VEC_TIMER_DEF,
  parameter logic [9:0] VEC_HALT  = VEC_HALT_DEF,
  parameter int         DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       int_clk,
  input  logic       int_halt,
  input  logic [9:0] save_pc,
  input  logic       rfe,
  input  logic       ie_we,
  input  logic       ie_data,
  output logic       pipe_stall,
  output logic       pc_redirect,
  output logic [9:0] redirect_pc,
  output logic [1:0] cause,
  output logic       in_handler,
  output logic [9:0] epc,
  output logic       overflow
);
`ifdef CTX_NEST_EN
  localparam bit NEST = 1'b1;
`else
  localparam bit NEST = 1'b0;
`endif
  localparam int SD = NEST ? DEPTH : 1;
  state_t state_q, state_d;
  cause_t cause_q, cause_d, next_cause;
  logic ie_q, ie_d, ph_q, ph_d, pt_q, pt_d, ov_q, ov_d;
  logic tmr_in, halt_req, req, take, drop, full, multi;
  logic [9:0] top_pc;
  assign tmr_in = int_clk & ie_q;
  assign halt_req = int_halt | ph_q;
  assign req = halt_req | tmr_in | pt_q;
  // Nested builds may also accept a new event while the handler runs, unless it is returning.
  assign take = req && (state_q == IDLE || (NEST && state_q == HANDLER && !rfe));
  assign drop = take && full;
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    ie_d = ie_we ? ie_data : ie_q;
    ph_d = (take && halt_req) ? 1'b0 : ph_q | int_halt;
    pt_d = (take && !halt_req) ? 1'b0 : pt_q | tmr_in;
    ov_d = ov_q | drop;
    if (take && !drop) begin
      state_d = SAVE;
      cause_d = halt_req ? CAUSE_HALT : CAUSE_TIMER;
    end else begin
      state_d = state_q == SAVE ? REDIRECT :
                state_q == REDIRECT ? HANDLER :
                (state_q == HANDLER && rfe) ? RETURN :
                state_q == RETURN ? ((NEST && multi) ? HANDLER : IDLE) : state_q;
      if (state_q == RETURN) cause_d = next_cause;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cause_q <= CAUSE_NONE;
      ie_q <= 1'b1;
      ph_q <= 1'b0;
      pt_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      ie_q <= ie_d;
      ph_q <= ph_d;
      pt_q <= pt_d;
      ov_q <= ov_d;
    end
  end
  epc_stack #(.DEPTH(SD)) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (state_q == SAVE),
    .pop       (state_q == RETURN),
    .din       ('{cause: cause_q, pc: save_pc}),
    .top_pc    (top_pc),
    .next_cause(next_cause),
    .full      (full),
    .multi     (multi)
  );
  assign pipe_stall = state_q == SAVE || state_q == REDIRECT;
  assign pc_redirect = state_q == REDIRECT || state_q == RETURN;
  assign redirect_pc = state_q == REDIRECT ? (cause_q == CAUSE_HALT ? VEC_HALT : VEC_TIMER) :
                       state_q == RETURN ? top_pc : '0;
  assign cause = cause_q;
  assign in_handler = state_q == HANDLER;
  assign epc = top_pc;
  assign overflow = NEST ? ov_q : 1'b0;
endmodule

// File: tb/tb_context_switch_ctrl.sv
// tb_context_switch_ctrl: directed scenario tests for context_switch_ctrl.
module tb_context_switch_ctrl;
  logic clk = 1'b0, rst = 1'b1, int_clk = 1'b0, int_halt = 1'b0, rfe = 1'b0, ie_we = 1'b0, ie_data = 1'b0;
  logic [9:0] save_pc = '0;
  logic pipe_stall, pc_redirect, in_handler, overflow;
  logic [9:0] redirect_pc, epc;
  logic [1:0] cause;
  int checks = 0, failures = 0;

  context_switch_ctrl dut (
    .clk(clk), .rst(rst), .int_clk(int_clk), .int_halt(int_halt), .save_pc(save_pc), .rfe(rfe),
    .ie_we(ie_we), .ie_data(ie_data), .pipe_stall(pipe_stall), .pc_redirect(pc_redirect),
    .redirect_pc(redirect_pc), .cause(cause), .in_handler(in_handler), .epc(epc), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (pipe_stall !== 1'b0) begin failures++; $display("FAIL rst_stall actual=%b required=0", pipe_stall); end
    checks++; if (pc_redirect !== 1'b0 || redirect_pc !== 10'h0) begin failures++; $display("FAIL rst_redir actual=%b/%h required=0/000", pc_redirect, redirect_pc); end
    checks++; if (cause !== 2'b00 || in_handler !== 1'b0) begin failures++; $display("FAIL rst_cause actual=%b/%b required=00/0", cause, in_handler); end
    checks++; if (epc !== 10'h0 || overflow !== 1'b0) begin failures++; $display("FAIL rst_epc actual=%h/%b required=000/0", epc, overflow); end
  endtask

  task automatic test_timer();
    int_clk = 1'b1; save_pc = 10'h123;
    step();
    int_clk = 1'b0;
    checks++; if (pipe_stall !== 1'b1 || pc_redirect !== 1'b0 || cause !== 2'b01) begin failures++; $display("FAIL tmr_save actual=%b/%b/%b required=1/0/01", pipe_stall, pc_redirect, cause); end
    step();
    checks++; if (pipe_stall !== 1'b1 || pc_redirect !== 1'b1 || redirect_pc !== 10'h004) begin failures++; $display("FAIL tmr_redir actual=%b/%b/%h required=1/1/004", pipe_stall, pc_redirect, redirect_pc); end
    checks++; if (epc !== 10'h123 || cause !== 2'b01) begin failures++; $display("FAIL tmr_epc actual=%h/%b required=123/01", epc, cause); end
    step();
    checks++; if (pipe_stall !== 1'b0 || pc_redirect !== 1'b0 || redirect_pc !== 10'h0 || in_handler !== 1'b1) begin failures++; $display("FAIL tmr_handler actual=%b/%b/%h/%b required=0/0/000/1", pipe_stall, pc_redirect, redirect_pc, in_handler); end
    rfe = 1'b1;
    step();
    rfe = 1'b0;
    checks++; if (pc_redirect !== 1'b1 || redirect_pc !== 10'h123 || in_handler !== 1'b0) begin failures++; $display("FAIL tmr_return actual=%b/%h/%b required=1/123/0", pc_redirect, redirect_pc, in_handler); end
    step();
    checks++; if (pc_redirect !== 1'b0 || cause !== 2'b00 || epc !== 10'h0) begin failures++; $display("FAIL tmr_idle actual=%b/%b/%h required=0/00/000", pc_redirect, cause, epc); end
  endtask

  task automatic test_rfe();
    rfe = 1'b1;
    step();
    rfe = 1'b0;
    checks++; if (pc_redirect !== 1'b0 || pipe_stall !== 1'b0) begin failures++; $display("FAIL rfe_idle_ignored actual=%b/%b required=0/0", pc_redirect, pipe_stall); end
    int_clk = 1'b1; save_pc = 10'h0AA;
    step();
    int_clk = 1'b0;
    step();
    step();
    step();
    rfe = 1'b1;
    step();
    rfe = 1'b0;
    checks++; if (pc_redirect !== 1'b1 || redirect_pc !== 10'h0AA) begin failures++; $display("FAIL rfe_return actual=%b/%h required=1/0aa", pc_redirect, redirect_pc); end
    step();
    checks++; if (cause !== 2'b00 || in_handler !== 1'b0 || pc_redirect !== 1'b0) begin failures++; $display("FAIL rfe_after actual=%b/%b/%b required=00/0/0", cause, in_handler, pc_redirect); end
  endtask

  task automatic test_both();
    int_clk = 1'b1; int_halt = 1'b1; save_pc = 10'h155;
    step();
    int_clk = 1'b0; int_halt = 1'b0;
    checks++; if (cause !== 2'b10) begin failures++; $display("FAIL both_cause actual=%b required=10", cause); end
    step();
    checks++; if (pc_redirect !== 1'b1 || redirect_pc !== 10'h008) begin failures++; $display("FAIL both_redir actual=%b/%h required=1/008", pc_redirect, redirect_pc); end
    step();
    rfe = 1'b1;
    step();
    rfe = 1'b0; save_pc = 10'h200;
    checks++; if (pc_redirect !== 1'b1 || redirect_pc !== 10'h155) begin failures++; $display("FAIL both_return actual=%b/%h required=1/155", pc_redirect, redirect_pc); end
    step();
    checks++; if (cause !== 2'b00 || pc_redirect !== 1'b0 || pipe_stall !== 1'b0) begin failures++; $display("FAIL both_idle actual=%b/%b/%b required=00/0/0", cause, pc_redirect, pipe_stall); end
    step();
    checks++; if (pipe_stall !== 1'b1 || cause !== 2'b01) begin failures++; $display("FAIL both_pend_save actual=%b/%b required=1/01", pipe_stall, cause); end
    step();
    checks++; if (pc_redirect !== 1'b1 || redirect_pc !== 10'h004 || epc !== 10'h200) begin failures++; $display("FAIL both_pend_redir actual=%b/%h/%h required=1/004/200", pc_redirect, redirect_pc, epc); end
    step();
    rfe = 1'b1;
    step();
    rfe = 1'b0;
    step();
  endtask

  task automatic test_masked();
    ie_we = 1'b1; ie_data = 1'b0;
    step();
    ie_we = 1'b0;
    int_clk = 1'b1; save_pc = 10'h0F0;
    step();
    int_clk = 1'b0;
    checks++; if (pipe_stall !== 1'b0 || cause !== 2'b00 || in_handler !== 1'b0) begin failures++; $display("FAIL mask_ignore actual=%b/%b/%b required=0/00/0", pipe_stall, cause, in_handler); end
    step();
    step();
    checks++; if (pipe_stall !== 1'b0 || pc_redirect !== 1'b0) begin failures++; $display("FAIL mask_no_pend actual=%b/%b required=0/0", pipe_stall, pc_redirect); end
    int_halt = 1'b1;
    step();
    int_halt = 1'b0;
    checks++; if (pipe_stall !== 1'b1 || cause !== 2'b10) begin failures++; $display("FAIL mask_halt_save actual=%b/%b required=1/10", pipe_stall, cause); end
    step();
    checks++; if (pc_redirect !== 1'b1 || redirect_pc !== 10'h008) begin failures++; $display("FAIL mask_halt_redir actual=%b/%h required=1/008", pc_redirect, redirect_pc); end
    step();
    rfe = 1'b1;
    step();
    rfe = 1'b0;
    checks++; if (redirect_pc !== 10'h0F0) begin failures++; $display("FAIL mask_return actual=%h required=0f0", redirect_pc); end
    step();
    ie_we = 1'b1; ie_data = 1'b1;
    step();
    ie_we = 1'b0;
  endtask

`ifndef CTX_NEST_EN
  task automatic test_pend_in_handler();
    int_clk = 1'b1; save_pc = 10'h044;
    step();
    int_clk = 1'b0;
    step();
    step();
    int_halt = 1'b1; save_pc = 10'h055;
    step();
    int_halt = 1'b0;
    checks++; if (in_handler !== 1'b1 || pc_redirect !== 1'b0 || epc !== 10'h044) begin failures++; $display("FAIL pend_hold actual=%b/%b/%h required=1/0/044", in_handler, pc_redirect, epc); end
    rfe = 1'b1;
    step();
    rfe = 1'b0;
    checks++; if (redirect_pc !== 10'h044) begin failures++; $display("FAIL pend_return actual=%h required=044", redirect_pc); end
    step();
    step();
    checks++; if (pipe_stall !== 1'b1 || cause !== 2'b10) begin failures++; $display("FAIL pend_service actual=%b/%b required=1/10", pipe_stall, cause); end
    step();
    step();
    rfe = 1'b1;
    step();
    rfe = 1'b0;
    step();
  endtask
`endif

  task automatic test_reset_mid();
    ie_we = 1'b1; ie_data = 1'b0;
    step();
    ie_we = 1'b0;
    int_halt = 1'b1; save_pc = 10'h033;
    step();
    int_halt = 1'b0;
    step();
    int_halt = 1'b1;
    step();
    int_halt = 1'b0;
    checks++; if (in_handler !== 1'b1 || epc !== 10'h033) begin failures++; $display("FAIL rmid_handler actual=%b/%h required=1/033", in_handler, epc); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (pipe_stall !== 1'b0 || pc_redirect !== 1'b0 || redirect_pc !== 10'h0 || cause !== 2'b00) begin failures++; $display("FAIL rmid_out actual=%b/%b/%h/%b required=0/0/000/00", pipe_stall, pc_redirect, redirect_pc, cause); end
    checks++; if (in_handler !== 1'b0 || epc !== 10'h0 || overflow !== 1'b0) begin failures++; $display("FAIL rmid_ctx actual=%b/%h/%b required=0/000/0", in_handler, epc, overflow); end
    step();
    checks++; if (pipe_stall !== 1'b0) begin failures++; $display("FAIL rmid_pend_cleared actual=%b required=0", pipe_stall); end
    int_clk = 1'b1;
    step();
    int_clk = 1'b0;
    checks++; if (pipe_stall !== 1'b1 || cause !== 2'b01) begin failures++; $display("FAIL rmid_ie_reset actual=%b/%b required=1/01", pipe_stall, cause); end
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

`ifdef CTX_NEST_EN
  task automatic test_nesting();
    for (int k = 1; k <= 4; k++) begin
      int_clk = 1'b1; save_pc = 10'h100 + 10'(k);
      step();
      int_clk = 1'b0;
      step();
      step();
      checks++; if (epc !== 10'h100 + 10'(k) || in_handler !== 1'b1) begin failures++; $display("FAIL nest_push%0d actual=%h/%b required=%h/1", k, epc, in_handler, 10'h100 + 10'(k)); end
    end
    int_clk = 1'b1; save_pc = 10'h1FF;
    step();
    int_clk = 1'b0;
    checks++; if (overflow !== 1'b1 || in_handler !== 1'b1 || epc !== 10'h104) begin failures++; $display("FAIL nest_overflow actual=%b/%b/%h required=1/1/104", overflow, in_handler, epc); end
    for (int k = 4; k >= 1; k--) begin
      rfe = 1'b1;
      step();
      rfe = 1'b0;
      checks++; if (pc_redirect !== 1'b1 || redirect_pc !== 10'h100 + 10'(k)) begin failures++; $display("FAIL nest_pop%0d actual=%b/%h required=1/%h", k, pc_redirect, redirect_pc, 10'h100 + 10'(k)); end
      step();
    end
    checks++; if (in_handler !== 1'b0 || cause !== 2'b00 || epc !== 10'h0) begin failures++; $display("FAIL nest_unwound actual=%b/%b/%h required=0/00/000", in_handler, cause, epc); end
  endtask
`endif

  initial begin
    test_reset();
    test_timer();
    test_rfe();
    test_both();
    test_masked();
`ifndef CTX_NEST_EN
    test_pend_in_handler();
`endif
    test_reset_mid();
`ifdef CTX_NEST_EN
    test_nesting();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
